// File: rtl/udp_demux_pkg.sv
// udp_demux_pkg: shared types and constants for the UDP destination-port demux.
//   demux_state_t  : IDLE / FORWARD / DROP controller states
//   udp_port_t     : 16-bit UDP port number
//   udp_len_t      : 16-bit UDP length / byte count
//   UDP_HDR_BYTES  : size of the UDP header counted in udp_length
//   sat_inc        : 16-bit increment that sticks at 16'hFFFF
package udp_demux_pkg;

   typedef logic [15:0] udp_port_t;
   typedef logic [15:0] udp_len_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FORWARD = 2'd1,
      DROP    = 2'd2
   } demux_state_t;

   localparam udp_len_t UDP_HDR_BYTES = 16'd8;

   function automatic udp_len_t sat_inc(input udp_len_t v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/udp_demux_stats.sv
// udp_demux_stats: per-datagram counter bank for udp_port_demux.
// Only compiled when UDP_PORT_DEMUX_STATS_EN is defined.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   frame_done        : forwarded datagram finished this cycle (tlast transfer)
//   frame_err         : tuser presented with that last beat
//   frame_channel     : channel the datagram was forwarded on
//   frame_drop        : one-cycle pulse per dropped datagram
//   stat_frames_ok    : per-channel 32-bit count of clean datagrams
//   stat_frames_err   : count of forwarded datagrams ending with tuser=1
//   stat_frames_drop  : count of dropped datagrams
// All counters are free-running and wrap.
`ifdef UDP_PORT_DEMUX_STATS_EN
module udp_demux_stats #(
   parameter int unsigned CHANNELS = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     frame_done,
   input  logic                     frame_err,
   input  logic [3:0]               frame_channel,
   input  logic                     frame_drop,
   output logic [CHANNELS*32-1:0]   stat_frames_ok,
   output logic [31:0]              stat_frames_err,
   output logic [31:0]              stat_frames_drop
);

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_frames_ok   <= '0;
         stat_frames_err  <= '0;
         stat_frames_drop <= '0;
      end else begin
         if (frame_done && frame_err)
            stat_frames_err <= stat_frames_err + 32'd1;
         if (frame_drop)
            stat_frames_drop <= stat_frames_drop + 32'd1;
         for (int i = 0; i < int'(CHANNELS); i++) begin
            if (frame_done && !frame_err && (frame_channel == 4'(i)))
               stat_frames_ok[i*32 +: 32] <= stat_frames_ok[i*32 +: 32] + 32'd1;
         end
      end
   end

endmodule
`endif

// File: rtl/udp_port_demux.sv
// udp_port_demux: steers received UDP datagrams to one of CHANNELS byte
// streams selected by destination port (PORT_BASE + channel). Datagrams to
// unmatched ports or with udp_length < MIN_UDP_LEN are consumed and dropped.
// A payload whose beat count disagrees with udp_length - 8 is flagged via
// m_axis_tuser on its last beat.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   s_udp_hdr_*, s_udp_*     : UDP header handshake and fields
//   s_udp_payload_axis_*     : 8-bit payload stream in
//   m_axis_tdata/tlast/tuser : shared payload out
//   m_axis_tvalid/tready     : one-hot per-channel handshake
//   m_src_ip, m_src_port     : source of the current datagram
//   m_channel                : channel of the current forwarded datagram
//   drop_pulse               : one pulse per dropped datagram
// Optional: define UDP_PORT_DEMUX_STATS_EN to add the stat_frames_* counters.
module udp_port_demux
   import udp_demux_pkg::*;
#(
   parameter int unsigned CHANNELS    = 4,
   parameter udp_port_t   PORT_BASE   = 16'd1234,
   parameter udp_len_t    MIN_UDP_LEN = 16'd8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_udp_hdr_valid,
   output logic                  s_udp_hdr_ready,
   input  logic [15:0]           s_udp_dest_port,
   input  logic [15:0]           s_udp_source_port,
   input  logic [31:0]           s_udp_ip_source_ip,
   input  logic [15:0]           s_udp_length,
   input  logic [7:0]            s_udp_payload_axis_tdata,
   input  logic                  s_udp_payload_axis_tvalid,
   output logic                  s_udp_payload_axis_tready,
   input  logic                  s_udp_payload_axis_tlast,
   input  logic                  s_udp_payload_axis_tuser,
   output logic [7:0]            m_axis_tdata,
   output logic [CHANNELS-1:0]   m_axis_tvalid,
   input  logic [CHANNELS-1:0]   m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic [31:0]           m_src_ip,
   output logic [15:0]           m_src_port,
   output logic [3:0]            m_channel,
   output logic                  drop_pulse
`ifdef UDP_PORT_DEMUX_STATS_EN
   ,
   output logic [CHANNELS*32-1:0] stat_frames_ok,
   output logic [31:0]            stat_frames_err,
   output logic [31:0]            stat_frames_drop
`endif
);

   localparam udp_port_t CH_LIMIT = udp_port_t'(CHANNELS);

   demux_state_t        state;
   logic                hdr_ready_q;
   udp_len_t            length_q;
   udp_len_t            byte_cnt;
   udp_len_t            cnt_inc;
   udp_port_t           idx;
   logic                hdr_fire;
   logic                hdr_match;
   logic                beat_fire;
   logic                last_fire;
   logic                sel_ready;
   logic                len_mismatch;
   logic [CHANNELS-1:0] ch_onehot;

   // Wraps for dest_port < PORT_BASE, so such ports fail the range test.
   assign idx       = s_udp_dest_port - PORT_BASE;
   assign hdr_match = (idx < CH_LIMIT) && (s_udp_length >= MIN_UDP_LEN);
   assign hdr_fire  = s_udp_hdr_valid & hdr_ready_q;
   assign s_udp_hdr_ready = hdr_ready_q;

   // Shift-based select avoids a 4-bit index into a narrower vector.
   assign ch_onehot = CHANNELS'(1) << m_channel;
   assign sel_ready = |(m_axis_tready & ch_onehot);

   always_comb begin
      s_udp_payload_axis_tready = 1'b0;
      m_axis_tvalid             = '0;
      case (state)
         FORWARD: begin
            s_udp_payload_axis_tready = sel_ready;
            m_axis_tvalid = s_udp_payload_axis_tvalid ? ch_onehot : '0;
         end
         DROP:    s_udp_payload_axis_tready = 1'b1;
         default: ;
      endcase
   end

   assign beat_fire = s_udp_payload_axis_tvalid & s_udp_payload_axis_tready;
   assign last_fire = beat_fire & s_udp_payload_axis_tlast;

   // The beat being presented would be number cnt_inc; on tlast that is the
   // delivered payload size, compared against what udp_length promised.
   assign cnt_inc      = sat_inc(byte_cnt);
   assign len_mismatch = (cnt_inc != (length_q - UDP_HDR_BYTES));

   assign m_axis_tdata = s_udp_payload_axis_tdata;
   assign m_axis_tlast = s_udp_payload_axis_tlast;
   assign m_axis_tuser = s_udp_payload_axis_tuser
                       | (s_udp_payload_axis_tlast & len_mismatch);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         hdr_ready_q <= 1'b0;
         length_q    <= '0;
         byte_cnt    <= '0;
         m_src_ip    <= '0;
         m_src_port  <= '0;
         m_channel   <= '0;
         drop_pulse  <= 1'b0;
      end else begin
         drop_pulse <= 1'b0;
         case (state)
            IDLE: begin
               hdr_ready_q <= 1'b1;
               if (hdr_fire) begin
                  hdr_ready_q <= 1'b0;
                  length_q    <= s_udp_length;
                  m_src_ip    <= s_udp_ip_source_ip;
                  m_src_port  <= s_udp_source_port;
                  byte_cnt    <= '0;
                  if (hdr_match) begin
                     state     <= FORWARD;
                     m_channel <= idx[3:0];
                  end else begin
                     state      <= DROP;
                     drop_pulse <= 1'b1;
                  end
               end
            end
            FORWARD: begin
               if (last_fire) begin
                  state       <= IDLE;
                  hdr_ready_q <= 1'b1;
                  byte_cnt    <= '0;
               end else if (beat_fire) begin
                  byte_cnt <= cnt_inc;
               end
            end
            DROP: begin
               if (last_fire) begin
                  state       <= IDLE;
                  hdr_ready_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UDP_PORT_DEMUX_STATS_EN
   udp_demux_stats #(
      .CHANNELS (CHANNELS)
   ) u_stats (
      .clk              (clk),
      .rst              (rst),
      .frame_done       ((state == FORWARD) && last_fire),
      .frame_err        (m_axis_tuser),
      .frame_channel    (m_channel),
      .frame_drop       (drop_pulse),
      .stat_frames_ok   (stat_frames_ok),
      .stat_frames_err  (stat_frames_err),
      .stat_frames_drop (stat_frames_drop)
   );
`endif

endmodule
